// File: rtl/spi_slave_core.sv
// -----------------------------------------------------------------------------
// spi_slave_core
//
// SPI responder datapath and control. The external master drives sck, ss_n
// and mosi asynchronously to clk; all three are oversampled through
// SYNC_STAGES flops. Edges of the synchronised sck are detected in the clk
// domain, so sck must run at least 8x slower than clk.
//
// Optional build macro: SPI_SLAVE_OVR_DETECT_EN
//   When defined, an extra output ovrf flags a frame that completed while
//   spif was still set; in that case rx_data keeps the unread byte.
//   When undefined, such a frame simply overwrites rx_data.
//
// Parameters
//   DATA_W       frame / buffer width in bits
//   SYNC_STAGES  synchronizer depth on sck, ss_n, mosi (>= 2)
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   sck      SPI clock from master (async)
//   ss_n     slave select, active low (async)
//   mosi     master-out data (async)
//   miso     slave-out data
//   miso_oe  miso pad output enable
//   cpol     clock idle level
//   cpha     0: sample on leading edge, 1: sample on trailing edge
//   lsbfe    1: LSB first, 0: MSB first
//   tx_data  byte to transmit
//   tx_wr    one-cycle write strobe for tx_data
//   rx_data  last received byte
//   rx_rd    one-cycle strobe, clears spif
//   spif     received byte available
//   sptef    transmit buffer empty
//   ovrf     receive overrun (only with SPI_SLAVE_OVR_DETECT_EN)
// -----------------------------------------------------------------------------
module spi_slave_core #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsbfe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_wr,
  output logic [DATA_W-1:0] rx_data,
  input  logic              rx_rd,
  output logic              spif,
  output logic              sptef
`ifdef SPI_SLAVE_OVR_DETECT_EN
  ,
  output logic              ovrf
`endif
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  // Pin index 0 = sck, 1 = ss_n, 2 = mosi. ss_n idles high, so its
  // synchronizer resets to 1 to avoid a false select after reset.
  localparam logic [2:0] SYNC_RST = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronizers
  // ---------------------------------------------------------------------------
  logic [2:0]             pin_vec;
  logic [SYNC_STAGES-1:0] sync_reg [3];

  assign pin_vec = {mosi, ss_n, sck};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync_reg[gi] <= {SYNC_STAGES{SYNC_RST[gi]}};
        end else begin
          sync_reg[gi] <= {sync_reg[gi][SYNC_STAGES-2:0], pin_vec[gi]};
        end
      end
    end
  endgenerate

  logic sck_s;
  logic ss_s;
  logic mosi_s;

  assign sck_s  = sync_reg[0][SYNC_STAGES-1];
  assign ss_s   = sync_reg[1][SYNC_STAGES-1];
  assign mosi_s = sync_reg[2][SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------------
  logic sck_d_reg;
  logic ss_d_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_d_reg <= 1'b0;
      ss_d_reg  <= 1'b1;
    end else begin
      sck_d_reg <= sck_s;
      ss_d_reg  <= ss_s;
    end
  end

  logic sck_rise;
  logic sck_fall;
  logic lead_edge;
  logic trail_edge;
  logic sample_edge;
  logic shift_edge;
  logic ss_fall;
  logic ss_rise;

  assign sck_rise    = sck_s & ~sck_d_reg;
  assign sck_fall    = ~sck_s & sck_d_reg;
  assign lead_edge   = cpol ? sck_fall : sck_rise;
  assign trail_edge  = cpol ? sck_rise : sck_fall;
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;
  assign ss_fall     = ss_d_reg & ~ss_s;
  assign ss_rise     = ~ss_d_reg & ss_s;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  state_t state_reg;
  state_t state_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (ss_fall) state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_SHIFT;
      ST_SHIFT: state_next = ST_SHIFT;
      default:  state_next = ST_IDLE;
    endcase
    if (ss_rise) begin
      state_next = ST_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: control outputs
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] bit_cnt_reg;
  logic             in_load;
  logic             do_sample;
  logic             shift_evt;
  logic             frame_done;
  logic             load_evt;

  always_comb begin
    in_load    = 1'b0;
    do_sample  = 1'b0;
    shift_evt  = 1'b0;
    frame_done = 1'b0;
    load_evt   = 1'b0;
    case (state_reg)
      ST_LOAD: begin
        in_load  = 1'b1;
        load_evt = 1'b1;
      end
      ST_SHIFT: begin
        if (!ss_rise) begin
          do_sample  = sample_edge;
          shift_evt  = shift_edge;
          frame_done = sample_edge && (bit_cnt_reg == LAST_BIT);
          load_evt   = frame_done;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transmit buffer
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] tx_buf_reg;
  logic              sptef_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_buf_reg <= '0;
      sptef_reg  <= 1'b1;
    end else begin
      if (tx_wr && sptef_reg) begin
        tx_buf_reg <= tx_data;
      end
      // A load empties the buffer; an accepted write fills it. They cannot
      // collide on the same buffer state because a write needs sptef=1 and
      // a consuming load needs sptef=0.
      if (load_evt && !sptef_reg) begin
        sptef_reg <= 1'b1;
      end else if (tx_wr && sptef_reg) begin
        sptef_reg <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shift registers and bit counter
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] tx_shift_reg;
  logic [DATA_W-1:0] rx_shift_reg;
  logic [DATA_W-1:0] rx_shift_next;
  logic              skip_reg;

  assign rx_shift_next = lsbfe ? {mosi_s, rx_shift_reg[DATA_W-1:1]}
                               : {rx_shift_reg[DATA_W-2:0], mosi_s};

  // skip_reg suppresses the next shift edge after a (re)load. With cpha=1
  // the first leading edge of a frame only presents the first bit. With
  // cpha=0 a reload lands on the last leading edge, and the trailing edge
  // that follows must not push the new first bit out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_shift_reg <= '0;
      skip_reg     <= 1'b0;
    end else if (load_evt) begin
      tx_shift_reg <= sptef_reg ? {DATA_W{1'b1}} : tx_buf_reg;
      skip_reg     <= in_load ? cpha : 1'b1;
    end else if (shift_evt) begin
      if (skip_reg) begin
        skip_reg <= 1'b0;
      end else if (lsbfe) begin
        tx_shift_reg <= {1'b0, tx_shift_reg[DATA_W-1:1]};
      end else begin
        tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_shift_reg <= '0;
      bit_cnt_reg  <= '0;
    end else begin
      if (do_sample) begin
        rx_shift_reg <= rx_shift_next;
      end
      if (in_load || ss_rise || frame_done) begin
        bit_cnt_reg <= '0;
      end else if (do_sample) begin
        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receive data and status
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rx_data_reg;
  logic              spif_reg;
  logic              rx_upd;

`ifdef SPI_SLAVE_OVR_DETECT_EN
  logic ovrf_reg;

  // An unread byte is protected: a completion while spif is set is an overrun.
  assign rx_upd = frame_done && !spif_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovrf_reg <= 1'b0;
    end else if (frame_done && spif_reg) begin
      ovrf_reg <= 1'b1;
    end else if (rx_rd) begin
      ovrf_reg <= 1'b0;
    end
  end

  assign ovrf = ovrf_reg;
`else
  assign rx_upd = frame_done;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_reg <= '0;
      spif_reg    <= 1'b0;
    end else begin
      if (rx_upd) begin
        rx_data_reg <= rx_shift_next;
      end
      // A completion in the same cycle as rx_rd keeps spif set.
      if (frame_done) begin
        spif_reg <= 1'b1;
      end else if (rx_rd) begin
        spif_reg <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pad side
  // ---------------------------------------------------------------------------
  logic miso_oe_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miso_oe_reg <= 1'b0;
    end else begin
      miso_oe_reg <= ~ss_s;
    end
  end

  assign miso    = lsbfe ? tx_shift_reg[0] : tx_shift_reg[DATA_W-1];
  assign miso_oe = miso_oe_reg;
  assign rx_data = rx_data_reg;
  assign spif    = spif_reg;
  assign sptef   = sptef_reg;

endmodule

// File: tb/tb_spi_slave_core.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_core
//
// Directed bench for spi_slave_core. The bench plays the SPI master with a
// half sck period of HALF clk cycles and checks every result against
// hand-computed values. Build with SPI_SLAVE_OVR_DETECT_EN defined to also
// exercise the overrun output.
// -----------------------------------------------------------------------------
module tb_spi_slave_core;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       sck;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic       cpol;
  logic       cpha;
  logic       lsbfe;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic [7:0] rx_data;
  logic       rx_rd;
  logic       spif;
  logic       sptef;
`ifdef SPI_SLAVE_OVR_DETECT_EN
  logic       ovrf;
`endif

  int n_total = 0;
  int n_bad   = 0;

  spi_slave_core #(
    .DATA_W      (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sck     (sck),
    .ss_n    (ss_n),
    .mosi    (mosi),
    .miso    (miso),
    .miso_oe (miso_oe),
    .cpol    (cpol),
    .cpha    (cpha),
    .lsbfe   (lsbfe),
    .tx_data (tx_data),
    .tx_wr   (tx_wr),
    .rx_data (rx_data),
    .rx_rd   (rx_rd),
    .spif    (spif),
    .sptef   (sptef)
`ifdef SPI_SLAVE_OVR_DETECT_EN
    ,
    .ovrf    (ovrf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] d);
    tx_data = d;
    tx_wr   = 1'b1;
    wait_clk(1);
    tx_wr   = 1'b0;
  endtask

  task automatic read_rx();
    rx_rd = 1'b1;
    wait_clk(1);
    rx_rd = 1'b0;
    wait_clk(1);
  endtask

  // Half period after a sample edge. With rd set, rx_rd is pulsed so that
  // it is high in exactly the clk cycle in which the slave sees the edge
  // (two synchronizer stages, then one cycle of edge detect).
  task automatic post_sample(input bit rd);
    if (rd) begin
      wait_clk(2);
      rx_rd = 1'b1;
      wait_clk(1);
      rx_rd = 1'b0;
      wait_clk(HALF - 3);
    end else begin
      wait_clk(HALF);
    end
  endtask

  task automatic spi_xfer(input logic [7:0] mo, input bit rd_at_end, output logic [7:0] mi);
    int b;
    mi = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b = lsbfe ? i : 7 - i;
      if (!cpha) begin
        mosi = mo[b];
        wait_clk(HALF);
        mi[b] = miso;
        sck = ~cpol;
        post_sample(rd_at_end && (i == 7));
        sck = cpol;
        wait_clk(HALF);
      end else begin
        sck  = ~cpol;
        mosi = mo[b];
        wait_clk(HALF);
        mi[b] = miso;
        sck = cpol;
        post_sample(rd_at_end && (i == 7));
      end
    end
  endtask

  task automatic select(input logic lvl);
    ss_n = lvl;
    wait_clk(8);
  endtask

  initial begin
    logic [7:0] mi;
    logic [7:0] mi2;
    logic [7:0] exp_rx;

    rst     = 1'b0;
    sck     = 1'b0;
    ss_n    = 1'b1;
    mosi    = 1'b0;
    cpol    = 1'b0;
    cpha    = 1'b0;
    lsbfe   = 1'b0;
    tx_data = 8'h00;
    tx_wr   = 1'b0;
    rx_rd   = 1'b0;
    wait_clk(3);
    rst = 1'b1;
    wait_clk(10);

    // Reset / idle state
    check_val("rst_spif", spif, 0);
    check_val("rst_sptef", sptef, 1);
    check_val("rst_miso_oe", miso_oe, 0);
    check_val("rst_rx_data", rx_data, 8'h00);
    check_val("rst_miso", miso, 0);
`ifdef SPI_SLAVE_OVR_DETECT_EN
    check_val("rst_ovrf", ovrf, 0);
`endif

    // Mode 0, MSB first: slave sends 0xA5, master sends 0x3C
    write_tx(8'hA5);
    check_val("m0_sptef_written", sptef, 0);
    select(1'b0);
    check_val("m0_sptef_after_load", sptef, 1);
    check_val("m0_miso_oe", miso_oe, 1);
    spi_xfer(8'h3C, 1'b0, mi);
    check_val("m0_miso_word", mi, 8'hA5);
    check_val("m0_rx_data", rx_data, 8'h3C);
    check_val("m0_spif", spif, 1);
    select(1'b1);
    check_val("m0_miso_oe_off", miso_oe, 0);
    read_rx();
    check_val("m0_spif_clr", spif, 0);

    // Mode 3, LSB first, no tx data: underrun pattern
    cpol  = 1'b1;
    cpha  = 1'b1;
    lsbfe = 1'b1;
    sck   = 1'b1;
    wait_clk(8);
    select(1'b0);
    spi_xfer(8'h81, 1'b0, mi);
    select(1'b1);
    check_val("m3_miso_word", mi, 8'hFF);
    check_val("m3_rx_data", rx_data, 8'h81);
    check_val("m3_spif", spif, 1);
    read_rx();
    cpol  = 1'b0;
    cpha  = 1'b0;
    lsbfe = 1'b0;
    sck   = 1'b0;
    wait_clk(8);

    // Back-to-back frames under one select, no rx_rd in between
    write_tx(8'h12);
    select(1'b0);
    write_tx(8'h34);
    check_val("b2b_sptef_refill", sptef, 0);
    spi_xfer(8'hA1, 1'b0, mi);
    spi_xfer(8'h5E, 1'b0, mi2);
    select(1'b1);
    check_val("b2b_miso_first", mi, 8'h12);
    check_val("b2b_miso_second", mi2, 8'h34);
    check_val("b2b_spif", spif, 1);
`ifdef SPI_SLAVE_OVR_DETECT_EN
    exp_rx = 8'hA1;
    check_val("b2b_ovrf", ovrf, 1);
`else
    exp_rx = 8'h5E;
`endif
    check_val("b2b_rx_data", rx_data, exp_rx);
    read_rx();
    check_val("b2b_spif_clr", spif, 0);
`ifdef SPI_SLAVE_OVR_DETECT_EN
    check_val("b2b_ovrf_clr", ovrf, 0);
`endif

    // Abort after 4 sck edges, then a fresh full frame
    select(1'b0);
    mosi = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sck = 1'b1;
      wait_clk(HALF);
      sck = 1'b0;
      wait_clk(HALF);
    end
    select(1'b1);
    check_val("abort_spif", spif, 0);
    check_val("abort_rx_data", rx_data, exp_rx);
    select(1'b0);
    spi_xfer(8'h55, 1'b0, mi);
    select(1'b1);
    check_val("fresh_rx_data", rx_data, 8'h55);
    check_val("fresh_spif", spif, 1);
    read_rx();

    // Write while full is ignored; rx_rd coincides with completion
    write_tx(8'h66);
    write_tx(8'h99);
    check_val("wr_full_sptef", sptef, 0);
    select(1'b0);
    check_val("wr_full_loaded", sptef, 1);
    spi_xfer(8'hC3, 1'b1, mi);
    select(1'b1);
    check_val("same_cyc_spif", spif, 1);
    check_val("same_cyc_rx_data", rx_data, 8'hC3);
    check_val("wr_full_miso_word", mi, 8'h66);
`ifdef SPI_SLAVE_OVR_DETECT_EN
    check_val("same_cyc_ovrf", ovrf, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
